// File: rtl/grid_accumulate_pkg.sv
// Shared grid constants, cell field layout and helpers for the grid write side
// and the statistics reader.
package grid_accumulate_pkg;

    localparam int CELL_W   = 48;
    localparam int GRAY_MSB = 47;
    localparam int GRAY_LSB = 32;
    localparam int CNT_MSB  = 31;
    localparam int CNT_LSB  = 24;
    localparam int DIST_MSB = 23;
    localparam int DIST_LSB = 0;

    localparam int ADDR_W         = 8;
    localparam int SAMPLE_W       = 16;
    localparam int MAX_VALUE_ADDR = 80;
    localparam int GRID_SHIFT     = 5;
    localparam int RAM_RD_LAT     = 2;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WAIT,
        WR
    } acc_state_t;

    function automatic logic [SAMPLE_W-1:0] sat_add16(input logic [SAMPLE_W-1:0] a,
                                                      input logic [SAMPLE_W-1:0] b);
        logic [SAMPLE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SAMPLE_W] ? {SAMPLE_W{1'b1}} : sum[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/grid_cell_update.sv
// Combinational cell update: folds one ranging sample into a grid cell and
// flags cells whose hit count can no longer grow.
module grid_cell_update
    import grid_accumulate_pkg::*;
(
    input  logic [CELL_W-1:0]   old_cell,
    input  logic [SAMPLE_W-1:0] sample_dist,
    input  logic [SAMPLE_W-1:0] sample_gray,
    output logic [CELL_W-1:0]   new_cell,
    output logic                saturated
);

    logic [GRAY_MSB-GRAY_LSB:0] gray_sum;
    logic [CNT_MSB-CNT_LSB:0]   count;
    logic [DIST_MSB-DIST_LSB:0] dist_sum;

    assign gray_sum  = old_cell[GRAY_MSB:GRAY_LSB];
    assign count     = old_cell[CNT_MSB:CNT_LSB];
    assign dist_sum  = old_cell[DIST_MSB:DIST_LSB];
    assign saturated = &count;

    // dist_sum cannot overflow: 255 samples of at most 16 bits fit in 24 bits.
    always_comb begin
        new_cell                    = '0;
        new_cell[GRAY_MSB:GRAY_LSB] = sat_add16(gray_sum, sample_gray);
        new_cell[CNT_MSB:CNT_LSB]   = count + 8'd1;
        new_cell[DIST_MSB:DIST_LSB] = dist_sum + {8'd0, sample_dist};
    end

endmodule

// File: rtl/grid_accumulate.sv
// Bins ranging samples into distance grid cells and read-modify-writes the
// ping-pong grid RAM bank that the statistics reader is not using.
module grid_accumulate
    import grid_accumulate_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                zero_flag,
    input  logic                tannis_change,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [SAMPLE_W-1:0] sample_dist,
    input  logic [SAMPLE_W-1:0] sample_gray,
    output logic                tannis1_left_wren,
    output logic [CELL_W-1:0]   tannis1_left_wrdata,
    output logic [ADDR_W-1:0]   tannis1_left_addr,
    output logic                tannis1_left_rden,
    input  logic [CELL_W-1:0]   tannis1_left_rddata,
    output logic                tannis2_left_wren,
    output logic [CELL_W-1:0]   tannis2_left_wrdata,
    output logic [ADDR_W-1:0]   tannis2_left_addr,
    output logic                tannis2_left_rden,
    input  logic [CELL_W-1:0]   tannis2_left_rddata,
    output logic [15:0]         drop_cnt
);

    localparam int                IDX_W     = SAMPLE_W - GRID_SHIFT;
    localparam int                WAIT_CYC  = RAM_RD_LAT - 1;
    localparam logic [IDX_W-1:0]  MAX_IDX   = IDX_W'(MAX_VALUE_ADDR);
    localparam logic [3:0]        WAIT_LAST = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

    acc_state_t state, next_state;

    logic [IDX_W-1:0]    sample_idx;
    logic                accept;
    logic                out_of_range;

    logic [ADDR_W-1:0]   idx_q;
    logic [SAMPLE_W-1:0] dist_q;
    logic [SAMPLE_W-1:0] gray_q;
    logic                bank2_q;
    logic [3:0]          wait_cnt;

    logic [CELL_W-1:0]   old_cell;
    logic [CELL_W-1:0]   new_cell;
    logic                cell_saturated;

    logic                rden1_d, rden2_d, wren1_d, wren2_d;
    logic [ADDR_W-1:0]   addr1_d, addr2_d;
    logic [CELL_W-1:0]   wrdata1_d, wrdata2_d;
    logic                drop_inc;

    assign sample_idx   = IDX_W'(sample_dist >> GRID_SHIFT);
    assign accept       = sample_valid & sample_ready;
    assign out_of_range = (sample_idx > MAX_IDX);
    assign old_cell     = bank2_q ? tannis2_left_rddata : tannis1_left_rddata;

    grid_cell_update u_cell_update (
        .old_cell    (old_cell),
        .sample_dist (dist_q),
        .sample_gray (gray_q),
        .new_cell    (new_cell),
        .saturated   (cell_saturated)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && !out_of_range) next_state = RD;
            RD:      next_state = (WAIT_CYC == 0) ? WR : WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) next_state = WR;
            WR:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the sample latches and wait counter carry no reset; they are always
    // loaded before use, and state/strobes are what reset must clear.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= sample_idx[ADDR_W-1:0];
            dist_q  <= sample_dist;
            gray_q  <= sample_gray;
            bank2_q <= tannis_change;
        end
        if (state == RD) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Next values of the registered RAM strobes; the read is launched straight
    // from the accept so rden appears the cycle after the sample is taken.
    always_comb begin
        rden1_d   = 1'b0;
        rden2_d   = 1'b0;
        wren1_d   = 1'b0;
        wren2_d   = 1'b0;
        addr1_d   = '0;
        addr2_d   = '0;
        wrdata1_d = '0;
        wrdata2_d = '0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (out_of_range) begin
                        drop_inc = 1'b1;
                    end else if (tannis_change) begin
                        rden2_d = 1'b1;
                        addr2_d = sample_idx[ADDR_W-1:0];
                    end else begin
                        rden1_d = 1'b1;
                        addr1_d = sample_idx[ADDR_W-1:0];
                    end
                end
            end
            WR: begin
                if (cell_saturated) begin
                    drop_inc = 1'b1;
                end else if (bank2_q) begin
                    wren2_d   = 1'b1;
                    addr2_d   = idx_q;
                    wrdata2_d = new_cell;
                end else begin
                    wren1_d   = 1'b1;
                    addr1_d   = idx_q;
                    wrdata1_d = new_cell;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_ready        <= 1'b0;
            tannis1_left_rden   <= 1'b0;
            tannis2_left_rden   <= 1'b0;
            tannis1_left_wren   <= 1'b0;
            tannis2_left_wren   <= 1'b0;
            tannis1_left_addr   <= '0;
            tannis2_left_addr   <= '0;
            tannis1_left_wrdata <= '0;
            tannis2_left_wrdata <= '0;
        end else begin
            sample_ready        <= (next_state == IDLE);
            tannis1_left_rden   <= rden1_d;
            tannis2_left_rden   <= rden2_d;
            tannis1_left_wren   <= wren1_d;
            tannis2_left_wren   <= wren2_d;
            tannis1_left_addr   <= addr1_d;
            tannis2_left_addr   <= addr2_d;
            tannis1_left_wrdata <= wrdata1_d;
            tannis2_left_wrdata <= wrdata2_d;
        end
    end

    // A revolution start clears the counter even if a drop lands the same cycle.
    always_ff @(posedge clk) begin
        if (rst || zero_flag) begin
            drop_cnt <= '0;
        end else if (drop_inc && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_grid_accumulate.sv
// Scoreboard bench for grid_accumulate: two latency-2 RAM models, a shadow grid
// predicting each write, and directed timing/boundary checks.
module tb_grid_accumulate;

    logic        clk = 1'b0;
    logic        rst;
    logic        zero_flag;
    logic        tannis_change;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] sample_dist;
    logic [15:0] sample_gray;
    logic        tannis1_left_wren, tannis2_left_wren;
    logic [47:0] tannis1_left_wrdata, tannis2_left_wrdata;
    logic [7:0]  tannis1_left_addr, tannis2_left_addr;
    logic        tannis1_left_rden, tannis2_left_rden;
    logic [47:0] tannis1_left_rddata, tannis2_left_rddata;
    logic [15:0] drop_cnt;

    typedef struct {
        logic        bank2;
        logic [7:0]  addr;
        logic [47:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [47:0] shadow[0:1][0:255];
    logic [47:0] mem1[0:255];
    logic [47:0] mem2[0:255];
    logic [47:0] p1a, p1b, p2a, p2b;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          exp_drop = 0;
    int          last_acc = 0;
    int          acc_t[4];

    grid_accumulate dut (
        .clk                 (clk),
        .rst                 (rst),
        .zero_flag           (zero_flag),
        .tannis_change       (tannis_change),
        .sample_valid        (sample_valid),
        .sample_ready        (sample_ready),
        .sample_dist         (sample_dist),
        .sample_gray         (sample_gray),
        .tannis1_left_wren   (tannis1_left_wren),
        .tannis1_left_wrdata (tannis1_left_wrdata),
        .tannis1_left_addr   (tannis1_left_addr),
        .tannis1_left_rden   (tannis1_left_rden),
        .tannis1_left_rddata (tannis1_left_rddata),
        .tannis2_left_wren   (tannis2_left_wren),
        .tannis2_left_wrdata (tannis2_left_wrdata),
        .tannis2_left_addr   (tannis2_left_addr),
        .tannis2_left_rden   (tannis2_left_rden),
        .tannis2_left_rddata (tannis2_left_rddata),
        .drop_cnt            (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Grid RAMs: rden sampled at an edge, data valid two cycles later.
    always @(posedge clk) begin
        if (tannis1_left_rden) p1a <= mem1[tannis1_left_addr];
        p1b <= p1a;
        if (tannis1_left_wren) mem1[tannis1_left_addr] <= tannis1_left_wrdata;
        if (tannis2_left_rden) p2a <= mem2[tannis2_left_addr];
        p2b <= p2a;
        if (tannis2_left_wren) mem2[tannis2_left_addr] <= tannis2_left_wrdata;
    end
    assign tannis1_left_rddata = p1b;
    assign tannis2_left_rddata = p2b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [15:0] d, input logic [15:0] g, input logic tc);
        int          idx;
        logic [47:0] c;
        logic [16:0] gs;
        wr_t         e;
        idx = int'(d) / 32;
        if (idx > 80) begin
            if (exp_drop < 65535) exp_drop++;
            return;
        end
        c = shadow[tc][idx];
        if (c[31:24] == 8'hFF) begin
            if (exp_drop < 65535) exp_drop++;
            return;
        end
        gs = {1'b0, c[47:32]} + {1'b0, g};
        c[47:32] = gs[16] ? 16'hFFFF : gs[15:0];
        c[31:24] = c[31:24] + 8'd1;
        c[23:0]  = c[23:0] + {8'd0, d};
        shadow[tc][idx] = c;
        e.bank2 = tc;
        e.addr  = idx[7:0];
        e.data  = c;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [15:0] d, input logic [15:0] g, input logic tc,
                        input bit do_model);
        int guard = 0;
        @(negedge clk);
        while (!sample_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check("ready_timeout", 0, 1);
        sample_valid  = 1'b1;
        sample_dist   = d;
        sample_gray   = g;
        tannis_change = tc;
        if (do_model) model(d, g, tc);
        @(posedge clk);
        #1;
        last_acc     = cyc;
        sample_valid = 1'b0;
    endtask

    task automatic preload(input logic tc, input int idx, input logic [47:0] v);
        shadow[tc][idx] = v;
        if (tc) mem2[idx] = v;
        else    mem1[idx] = v;
    endtask

    // Scoreboard: every write strobe must match the next predicted write.
    always @(negedge clk) begin
        wr_t e;
        check("dual_rden", tannis1_left_rden & tannis2_left_rden, 0);
        if (!tannis1_left_wren) check("wrdata1_idle", tannis1_left_wrdata, 0);
        if (!tannis2_left_wren) check("wrdata2_idle", tannis2_left_wrdata, 0);
        if (tannis1_left_wren || tannis2_left_wren) begin
            check("dual_wren", tannis1_left_wren & tannis2_left_wren, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_wren", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_bank", tannis2_left_wren, e.bank2);
                check("wr_addr", tannis2_left_wren ? tannis2_left_addr : tannis1_left_addr, e.addr);
                check("wr_data", tannis2_left_wren ? tannis2_left_wrdata : tannis1_left_wrdata, e.data);
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; zero_flag = 1'b0; tannis_change = 1'b0; sample_valid = 1'b0;
        sample_dist = '0; sample_gray = '0;
        p1a = '0; p1b = '0; p2a = '0; p2b = '0;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = '0; mem2[i] = '0; shadow[0][i] = '0; shadow[1][i] = '0;
        end

        repeat (3) @(negedge clk);
        check("rst_ready", sample_ready, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_rden1", tannis1_left_rden, 0);
        check("rst_wren1", tannis1_left_wren, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", sample_ready, 1);

        // Single sample: read at T+1, write at T+4.
        send(16'd100, 16'd40, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_rden1", tannis1_left_rden, 1);
        check("t1_addr1", tannis1_left_addr, 3);
        check("t1_rden2", tannis2_left_rden, 0);
        check("t1_ready_low", sample_ready, 0);
        @(negedge clk);
        check("t2_wren1", tannis1_left_wren, 0);
        @(negedge clk);
        check("t3_wren1", tannis1_left_wren, 0);
        @(negedge clk);
        check("t4_wren1", tannis1_left_wren, 1);
        check("t4_addr1", tannis1_left_addr, 3);
        check("t4_wrdata1", tannis1_left_wrdata, {16'd40, 8'd1, 24'd100});
        check("t4_wren2", tannis2_left_wren, 0);
        check("t4_ready", sample_ready, 1);

        // Same-cell burst on bank 2 at full throughput.
        for (int i = 0; i < 4; i++) begin
            send(16'(96 + i), 16'd10, 1'b1, 1'b1);
            acc_t[i] = last_acc;
        end
        for (int i = 1; i < 4; i++) check("burst_spacing", acc_t[i] - acc_t[i-1], 4);
        repeat (8) @(negedge clk);
        check("burst_cell", mem2[3], {16'd40, 8'd4, 24'd390});
        check("burst_bank1_untouched", mem1[3], {16'd40, 8'd1, 24'd100});

        // Out of range drop and highest valid index.
        send(16'd2600, 16'd5, 1'b0, 1'b1);
        @(negedge clk);
        check("oor_ready", sample_ready, 1);
        check("oor_rden1", tannis1_left_rden, 0);
        check("oor_rden2", tannis2_left_rden, 0);
        check("oor_drop", drop_cnt, 16'(exp_drop));
        send(16'd2591, 16'd1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check("max_idx_cell", mem1[80], {16'd1, 8'd1, 24'd2591});
        check("max_idx_drop", drop_cnt, 16'(exp_drop));

        // Saturated count and saturated gray sum.
        preload(1'b0, 5, {16'd7, 8'd255, 24'd1000});
        preload(1'b0, 6, {16'hFFF0, 8'd1, 24'd100});
        send(16'd160, 16'd3, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check("cnt_sat_drop", drop_cnt, 16'(exp_drop));
        check("cnt_sat_cell", mem1[5], {16'd7, 8'd255, 24'd1000});
        send(16'd192, 16'h20, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check("gray_sat_cell", mem1[6], {16'hFFFF, 8'd2, 24'd292});

        // Bank switch while a write is in flight.
        send(16'd224, 16'd5, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 tannis_change = 1'b1;
        send(16'd224, 16'd6, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        check("switch_bank1", mem1[7], {16'd5, 8'd1, 24'd224});
        check("switch_bank2", mem2[7], {16'd6, 8'd1, 24'd224});

        // Reset mid-RMW: the in-flight sample must never be written.
        check("pre_rst_drop", drop_cnt, 16'(exp_drop));
        send(16'd64, 16'd9, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", sample_ready, 0);
        check("mid_rst_wren1", tannis1_left_wren, 0);
        check("mid_rst_rden1", tannis1_left_rden, 0);
        check("mid_rst_addr1", tannis1_left_addr, 0);
        check("mid_rst_drop", drop_cnt, 0);
        rst = 1'b0;
        exp_drop = 0;
        repeat (8) @(negedge clk);
        check("rst_no_write", mem1[2], 0);
        check("rst_ready_back", sample_ready, 1);

        // zero_flag clears the counter, also against a coincident drop.
        send(16'd3000, 16'd1, 1'b0, 1'b1);
        send(16'd4000, 16'd1, 1'b0, 1'b1);
        @(negedge clk);
        check("two_drops", drop_cnt, 16'(exp_drop));
        zero_flag = 1'b1;
        @(negedge clk);
        zero_flag = 1'b0;
        exp_drop = 0;
        check("zero_clear", drop_cnt, 0);
        send(16'd3000, 16'd1, 1'b0, 1'b1);
        @(negedge clk);
        check("drop_after_zero", drop_cnt, 1);
        @(negedge clk);
        sample_valid = 1'b1; sample_dist = 16'd5000; sample_gray = 16'd1; zero_flag = 1'b1;
        @(posedge clk);
        #1 sample_valid = 1'b0; zero_flag = 1'b0;
        exp_drop = 0;
        @(negedge clk);
        check("zero_wins", drop_cnt, 0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
